cordic_req_arbiter: RTL and testbench

//  Shares one sin/cos CORDIC (1 phase/cycle, fixed latency) between N_REQ requesters.

---
 rtl/cordic_arb_pkg.sv | 17 +
 rtl/cordic_rr_arbiter.sv | 32 +++
 rtl/cordic_req_arbiter.sv | 161 ++++++++++++++++
 tb/tb_cordic_req_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_arb_pkg.sv
// Shared constants and the in-flight tag type for the CORDIC request arbiter.
package cordic_arb_pkg;

   localparam int unsigned PHASE_W       = 16;
   localparam int unsigned DOUT_W        = 32;
   localparam logic [15:0] PHASE_PI      = 16'h8000;
   localparam logic [15:0] PHASE_HALF_PI = 16'h4000;

   // Widest requester ID a tag can carry (N_REQ up to 8).
   localparam int unsigned TAG_ID_W      = 3;

   typedef struct packed {
      logic                vld;
      logic [TAG_ID_W-1:0] id;
   } arb_tag_t;

endpackage

// File: rtl/cordic_rr_arbiter.sv
// Combinational round-robin grant: searches upward from ptr (mod N_REQ) and
// grants the first asserted request; nothing is granted while en is low.
module cordic_rr_arbiter #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned ID_W  = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   input  logic             en,
   output logic [N_REQ-1:0] gnt,
   output logic [ID_W-1:0]  gnt_idx,
   output logic             any
);

   // First valid requester at or after ptr, wrapping around
   always_comb begin
      logic [ID_W-1:0] idx;
      gnt     = '0;
      gnt_idx = '0;
      any     = 1'b0;
      idx     = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         idx = ID_W'((32'(ptr) + k) % N_REQ);
         if (en && !any && req[idx]) begin
            any      = 1'b1;
            gnt[idx] = 1'b1;
            gnt_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/cordic_req_arbiter.sv
// Shares one sin/cos CORDIC between N_REQ requesters: round-robin phase grant,
// registered issue, latency-matched ID tags, and a shared {cos,sin} response bus.
// Optional build macro CORDIC_ARB_STATS_EN adds saturating grant/stall counters.
module cordic_req_arbiter
   import cordic_arb_pkg::*;
#(
   parameter  int unsigned N_REQ   = 4,
   parameter  int unsigned LATENCY = 1,
   localparam int unsigned ID_W    = $clog2(N_REQ)
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   input  logic                     enable,
   input  logic [N_REQ-1:0]         req_valid,
   output logic [N_REQ-1:0]         req_ready,
   input  logic [N_REQ*PHASE_W-1:0] req_phase,
   output logic                     cordic_phase_tvalid,
   output logic [PHASE_W-1:0]       cordic_phase_tdata,
   input  logic                     cordic_dout_tvalid,
   input  logic [DOUT_W-1:0]        cordic_dout_tdata,
   output logic                     rsp_valid,
   output logic [ID_W-1:0]          rsp_id,
   output logic [DOUT_W-1:0]        rsp_data,
   output logic                     idle,
   output logic                     err_orphan
`ifdef CORDIC_ARB_STATS_EN
   ,
   output logic [N_REQ*16-1:0]      grant_cnt,
   output logic [15:0]              stall_cnt
`endif
);

   localparam int unsigned MASK_W = $clog2(LATENCY + 2);

   logic [N_REQ-1:0]   gnt;
   logic [ID_W-1:0]    gnt_idx;
   logic               gnt_any;
   logic [ID_W-1:0]    rr_ptr;
   logic [ID_W-1:0]    issue_id;
   logic [PHASE_W-1:0] gnt_phase;
   arb_tag_t           tags [LATENCY];
   arb_tag_t           tag_in;
   arb_tag_t           tail;
   logic               tags_busy;
   logic [MASK_W-1:0]  mask_cnt;

   cordic_rr_arbiter #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_rr (
      .req     (req_valid),
      .ptr     (rr_ptr),
      .en      (enable),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .any     (gnt_any)
   );

   assign req_ready = gnt;
   assign gnt_phase = req_phase[PHASE_W*gnt_idx +: PHASE_W];
   assign tail      = tags[LATENCY-1];

   // Pointer moves past the last winner; holds when nothing is granted
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rr_ptr <= '0;
      end else if (gnt_any) begin
         rr_ptr <= (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
      end
   end

   // Registered issue toward the CORDIC; tdata holds between grants
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         cordic_phase_tvalid <= 1'b0;
         cordic_phase_tdata  <= '0;
         issue_id            <= '0;
      end else begin
         cordic_phase_tvalid <= gnt_any;
         if (gnt_any) begin
            cordic_phase_tdata <= gnt_phase;
            issue_id           <= gnt_idx;
         end
      end
   end

   // Tag entering the shift is the one currently presented to the CORDIC
   always_comb begin
      tag_in     = '0;
      tag_in.vld = cordic_phase_tvalid;
      tag_in.id  = TAG_ID_W'(issue_id);
   end

   // Tag pipeline matches CORDIC latency so the tail lines up with dout
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int unsigned i = 0; i < LATENCY; i++) tags[i] <= '0;
      end else begin
         tags[0] <= tag_in;
         for (int unsigned i = 1; i < LATENCY; i++) tags[i] <= tags[i-1];
      end
   end

   // Anything still travelling through issue or tag stages
   always_comb begin
      tags_busy = cordic_phase_tvalid;
      for (int unsigned i = 0; i < LATENCY; i++) tags_busy = tags_busy | tags[i].vld;
      idle = !tags_busy && !gnt_any;
   end

   // Counts down after reset to ignore stale CORDIC outputs (CORDIC is not reset)
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         mask_cnt <= MASK_W'(LATENCY);
      end else if (mask_cnt != '0) begin
         mask_cnt <= mask_cnt - MASK_W'(1);
      end
   end

   // Response register: forward dout with the matching tag's ID
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_data  <= '0;
      end else begin
         rsp_valid <= cordic_dout_tvalid && tail.vld;
         if (cordic_dout_tvalid && tail.vld) begin
            rsp_id   <= ID_W'(tail.id);
            rsp_data <= cordic_dout_tdata;
         end
      end
   end

   // Sticky error on any dout/tag disagreement once the mask period is over
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         err_orphan <= 1'b0;
      end else if (mask_cnt == '0 && (cordic_dout_tvalid != tail.vld)) begin
         err_orphan <= 1'b1;
      end
   end

`ifdef CORDIC_ARB_STATS_EN
   // Per-requester grant counters and stall counter, saturating at all-ones
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         grant_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         for (int unsigned i = 0; i < N_REQ; i++) begin
            if (gnt[i] && grant_cnt[16*i +: 16] != '1)
               grant_cnt[16*i +: 16] <= grant_cnt[16*i +: 16] + 16'd1;
         end
         if (|req_valid && !gnt_any && stall_cnt != '1)
            stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_cordic_req_arbiter.sv
// Scoreboard bench for cordic_req_arbiter with a behavioural CORDIC (LATENCY=1).
// Stats ports are exercised when built with CORDIC_ARB_STATS_EN.
module tb_cordic_req_arbiter;
   import cordic_arb_pkg::*;

   localparam int N   = 4;
   localparam int LAT = 1;

   logic           aclk;
   logic           aresetn;
   logic           enable;
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready;
   logic [N*16-1:0] req_phase;
   logic           cordic_phase_tvalid;
   logic [15:0]    cordic_phase_tdata;
   logic           cordic_dout_tvalid;
   logic [31:0]    cordic_dout_tdata;
   logic           rsp_valid;
   logic [1:0]     rsp_id;
   logic [31:0]    rsp_data;
   logic           idle;
   logic           err_orphan;
`ifdef CORDIC_ARB_STATS_EN
   logic [N*16-1:0] grant_cnt;
   logic [15:0]     stall_cnt;
`endif

   cordic_req_arbiter #(.N_REQ(N), .LATENCY(LAT)) dut (
      .aclk                (aclk),
      .aresetn             (aresetn),
      .enable              (enable),
      .req_valid           (req_valid),
      .req_ready           (req_ready),
      .req_phase           (req_phase),
      .cordic_phase_tvalid (cordic_phase_tvalid),
      .cordic_phase_tdata  (cordic_phase_tdata),
      .cordic_dout_tvalid  (cordic_dout_tvalid),
      .cordic_dout_tdata   (cordic_dout_tdata),
      .rsp_valid           (rsp_valid),
      .rsp_id              (rsp_id),
      .rsp_data            (rsp_data),
      .idle                (idle),
      .err_orphan          (err_orphan)
`ifdef CORDIC_ARB_STATS_EN
      ,
      .grant_cnt           (grant_cnt),
      .stall_cnt           (stall_cnt)
`endif
   );

   int     checks = 0;
   int     errors = 0;
   longint cyc    = 0;

   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   always @(posedge aclk) cyc <= cyc + 1;

   // Ideal sin/cos in Q2.14; phase 2^15 = pi
   function automatic logic [15:0] trig(logic [15:0] ph, bit want_cos, int jit);
      real a, v;
      int  r;
      a = real'($signed(ph)) * 3.14159265358979 / 32768.0;
      v = want_cos ? $cos(a) : $sin(a);
      r = int'(v * 16384.0) + jit;
      return 16'(r);
   endfunction

   // Behavioural CORDIC, one-cycle latency, not reset, small output jitter
   logic force_dout = 1'b0;
   always @(posedge aclk) begin
      cordic_dout_tvalid <= cordic_phase_tvalid | force_dout;
      cordic_dout_tdata  <= {trig(cordic_phase_tdata, 1'b1, int'($urandom_range(0, 2)) - 1),
                             trig(cordic_phase_tdata, 1'b0, int'($urandom_range(0, 2)) - 1)};
   end

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_near(string name, logic [15:0] act, logic [15:0] exp);
      int d;
      checks++;
      d = int'($signed(act)) - int'($signed(exp));
      if (d < -4 || d > 4) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h+/-4 (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      int          id;
      logic [15:0] ph;
      longint      due;
   } exp_t;
   exp_t sbq[$];

   // Reference model state
   logic [N-1:0] want = '0;
   bit           en_cfg = 1'b1;
   bit           rand_phase = 1'b0;
   logic [15:0]  dir_ph [N];
   int           mptr = 0;
   bit           prev_any = 1'b0;
   logic [15:0]  prev_phase = '0;
   logic [N-1:0] hs_last = '0;
   bit           exp_orphan = 1'b0;
   int           stall_model = 0;
   int           gcnt_model [N];

   // One cycle: drive at negedge, predict grant, check, enqueue expected response
   task automatic step();
      logic [N-1:0] nv;
      int best, bestd, d;
      bit pending;
      @(negedge aclk);
      enable = en_cfg;
      nv = req_valid & ~hs_last;
      for (int i = 0; i < N; i++) begin
         if (!nv[i] && want[i]) begin
            nv[i] = 1'b1;
            req_phase[16*i +: 16] = rand_phase ? 16'($urandom) : dir_ph[i];
         end
      end
      req_valid = nv;
      #1;
      chk("issue_vld", cordic_phase_tvalid, prev_any);
      if (prev_any) chk("issue_data", cordic_phase_tdata, prev_phase);
      best  = -1;
      bestd = N;
      if (enable) begin
         for (int i = 0; i < N; i++) begin
            d = (i - mptr + N) % N;
            if (req_valid[i] && d < bestd) begin
               best  = i;
               bestd = d;
            end
         end
      end
      pending = 1'b0;
      foreach (sbq[k]) if (sbq[k].due > cyc) pending = 1'b1;
      chk("idle", idle, (best < 0) && !pending);
      chk("req_ready", req_ready, (best >= 0) ? (64'd1 << best) : 64'd0);
      chk("err_orphan", err_orphan, exp_orphan);
      if (|req_valid && best < 0) stall_model++;
      if (best >= 0) begin
         sbq.push_back('{id: best, ph: req_phase[16*best +: 16], due: cyc + 3});
         gcnt_model[best]++;
         mptr       = (best + 1) % N;
         prev_phase = req_phase[16*best +: 16];
         prev_any   = 1'b1;
      end else begin
         prev_any = 1'b0;
      end
      hs_last = req_valid & req_ready;
   endtask

   task automatic do_reset(int n);
      @(negedge aclk);
      aresetn   = 1'b0;
      req_valid = '0;
      sbq.delete();
      mptr        = 0;
      prev_any    = 1'b0;
      hs_last     = '0;
      stall_model = 0;
      foreach (gcnt_model[i]) gcnt_model[i] = 0;
      repeat (n) @(negedge aclk);
      aresetn = 1'b1;
   endtask

   // Monitor: pop and compare whenever a response appears or one is overdue
   initial begin
      exp_t e;
      forever begin
         @(negedge aclk);
         #2;
         if (aresetn) begin
            if (rsp_valid) begin
               if (sbq.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL rsp_unexpected actual id=%0d required=no response (t=%0t)", rsp_id, $time);
               end else begin
                  e = sbq.pop_front();
                  chk("rsp_time", 64'(cyc), 64'(e.due));
                  chk("rsp_id", rsp_id, 64'(e.id));
                  chk_near("rsp_cos", rsp_data[31:16], trig(e.ph, 1'b1, 0));
                  chk_near("rsp_sin", rsp_data[15:0], trig(e.ph, 1'b0, 0));
               end
            end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
               e = sbq.pop_front();
               checks++;
               errors++;
               $display("FAIL rsp_missing actual=none required id=%0d (t=%0t)", e.id, $time);
            end
         end
      end
   end

   initial begin
      aresetn   = 1'b0;
      enable    = 1'b0;
      req_valid = '0;
      req_phase = '0;
      foreach (gcnt_model[i]) gcnt_model[i] = 0;
      foreach (dir_ph[i]) dir_ph[i] = '0;
      repeat (3) @(negedge aclk);
      #1;
      chk("rst_ready", req_ready, 0);
      chk("rst_tvalid", cordic_phase_tvalid, 0);
      chk("rst_tdata", cordic_phase_tdata, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_err", err_orphan, 0);
      chk("rst_idle", idle, 1);
      @(negedge aclk);
      aresetn = 1'b1;

      // Single request from requester 0
      en_cfg = 1'b1;
      want = 4'b0001;
      step();
      want = '0;
      repeat (6) step();

      // Fairness with all four continuously valid
      dir_ph[0] = 16'h0000;
      dir_ph[1] = PHASE_HALF_PI;
      dir_ph[2] = PHASE_PI;
      dir_ph[3] = 16'hC000;
      want = '1;
      repeat (12) step();
      want = '0;
      repeat (6) step();

      // Pointer after repeated grants to requester 2
      want = 4'b0100;
      repeat (3) step();
      want = 4'b1010;
      repeat (2) step();
      want = '0;
      repeat (6) step();

      // Enable drops with two results in flight
      want = 4'b0011;
      repeat (2) step();
      en_cfg = 1'b0;
      repeat (6) step();
      want   = '0;
      en_cfg = 1'b1;
      repeat (6) step();

      // Randomised traffic
      rand_phase = 1'b1;
      repeat (300) begin
         want   = N'($urandom);
         en_cfg = ($urandom_range(0, 9) != 0);
         step();
      end
      want   = '0;
      en_cfg = 1'b1;
      repeat (6) step();

`ifdef CORDIC_ARB_STATS_EN
      chk("stall_cnt", stall_cnt, 64'(stall_model));
      for (int i = 0; i < N; i++) chk("grant_cnt", grant_cnt[16*i +: 16], 64'(gcnt_model[i]));
`endif

      // Reset in the middle of a back-to-back stream
      want = '1;
      repeat (5) step();
      want = '0;
      do_reset(2);
      repeat (8) step();

      // Stray dout with no tag after the mask period
      @(negedge aclk);
      force_dout = 1'b1;
      @(negedge aclk);
      force_dout = 1'b0;
      exp_orphan = 1'b1;
      repeat (4) step();
      do_reset(2);
      exp_orphan = 1'b0;
      repeat (3) step();

      // Bounded drain of anything still expected
      for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge aclk);
      if (sbq.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain actual=%0d pending required=0", sbq.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
